// File: rtl/spi_command_dispatcher.sv
// Decodes framed SPI bytes into sprite-RAM write strobes (SAVE) and 48-bit draw records (DRAW).
// Latency: one cycle from a byte's byte_valid to its write strobe, error pulse or FIFO entry.
// Backpressure: byte input is never stalled; draw records that find the FIFO full are dropped and counted.

// Small first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible at the head one cycle later; a pop frees its slot on the same edge.
// Backpressure: push is accepted while not full, or when full if a pop happens in the same cycle.
module spi_cmd_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic          push_ok_o,
  output logic          vld_o,
  output logic [W-1:0]  dat_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = CW - 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q < CW'(DEPTH)) || pop_ok);

  // Storage array; contents are qualified by count so it needs no reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign push_ok_o = push_ok;
  assign vld_o     = (count_q != '0);
  // Head is forced to zero when empty so the output reads 0 out of reset.
  assign dat_o     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

module spi_command_dispatcher #(
  parameter logic [7:0] CMD_SAVE_SPRITE = 8'h01,
  parameter logic [7:0] CMD_DRAW_SPRITE = 8'h02,
  parameter int         SPRITE_ID_W     = 5,
  parameter int         FIFO_DEPTH      = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cs,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         mem_we,
  output logic [SPRITE_ID_W+8:0]       mem_addr,
  output logic [7:0]                   mem_wdata,
  output logic                         draw_valid,
  output logic [47:0]                  draw_data,
  input  logic                         draw_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         busy,
  output logic                         err_unknown_cmd,
  output logic                         err_bad_id,
  output logic [7:0]                   drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SAVE_ID   = 2'd1,
    S_SAVE_PIX  = 2'd2,
    S_DRAW_ARGS = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SPRITE_ID_W-1:0] sprite_id_q;
  logic                   suppress_q;
  logic [8:0]             pix_cnt_q;
  logic [2:0]             arg_cnt_q;
  logic [39:0]            args_q;
  logic                   mem_we_q;
  logic [SPRITE_ID_W+8:0] mem_addr_q;
  logic [7:0]             mem_wdata_q;
  logic                   err_unk_q;
  logic                   err_bad_q;
  logic [7:0]             drop_q;

  logic                   byte_in;
  logic [15:0]            id_ext;
  logic                   id_bad;
  logic                   draw_push_d;
  logic [47:0]            draw_rec_d;
  logic                   push_ok;

  // A byte only counts when the frame is active; cs wins over a coincident byte.
  assign byte_in = byte_valid && !cs;

  // Widened compare so the range check also works when SPRITE_ID_W covers the whole byte.
  assign id_ext = {8'd0, byte_data};
  assign id_bad = (id_ext >= (16'd1 << SPRITE_ID_W));

  // The sixth argument byte completes the record and is pushed on the same edge.
  assign draw_push_d = byte_in && (state_q == S_DRAW_ARGS) && (arg_cnt_q == 3'd5);
  assign draw_rec_d  = {args_q, byte_data};

  // Command sequencer: decodes opcodes, walks argument/pixel bytes, drives registered strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sprite_id_q <= '0;
      suppress_q  <= 1'b0;
      pix_cnt_q   <= '0;
      arg_cnt_q   <= '0;
      args_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_unk_q   <= 1'b0;
      err_bad_q   <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      err_unk_q <= 1'b0;
      err_bad_q <= 1'b0;
      if (cs) begin
        // Frame abort: drop any partial command, keep whatever was already written.
        state_q     <= S_IDLE;
        sprite_id_q <= '0;
        suppress_q  <= 1'b0;
        pix_cnt_q   <= '0;
        arg_cnt_q   <= '0;
        args_q      <= '0;
      end else if (byte_in) begin
        case (state_q)
          S_IDLE: begin
            if (byte_data == CMD_SAVE_SPRITE) begin
              state_q <= S_SAVE_ID;
            end else if (byte_data == CMD_DRAW_SPRITE) begin
              state_q   <= S_DRAW_ARGS;
              arg_cnt_q <= '0;
            end else begin
              err_unk_q <= 1'b1;
            end
          end
          S_SAVE_ID: begin
            // An out-of-range id still consumes the full pixel payload, just silently.
            sprite_id_q <= byte_data[SPRITE_ID_W-1:0];
            suppress_q  <= id_bad;
            err_bad_q   <= id_bad;
            pix_cnt_q   <= '0;
            state_q     <= S_SAVE_PIX;
          end
          S_SAVE_PIX: begin
            if (!suppress_q) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {sprite_id_q, pix_cnt_q};
              mem_wdata_q <= byte_data;
            end
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_cnt_q == 9'd511) begin
              state_q    <= S_IDLE;
              suppress_q <= 1'b0;
            end
          end
          S_DRAW_ARGS: begin
            args_q    <= {args_q[31:0], byte_data};
            arg_cnt_q <= arg_cnt_q + 1'b1;
            if (arg_cnt_q == 3'd5) begin
              state_q   <= S_IDLE;
              arg_cnt_q <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Count records lost to a full FIFO, sticking at 255.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
    end else if (draw_push_d && !push_ok && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  spi_cmd_fifo #(
    .W     (48),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_draw_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (draw_push_d),
    .push_dat_i (draw_rec_d),
    .pop_i      (draw_ready),
    .push_ok_o  (push_ok),
    .vld_o      (draw_valid),
    .dat_o      (draw_data),
    .count_o    (fifo_count)
  );

  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign busy            = (state_q != S_IDLE);
  assign err_unknown_cmd = err_unk_q;
  assign err_bad_id      = err_bad_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_spi_command_dispatcher.sv
// Bench for spi_command_dispatcher: directed scenarios plus random traffic against a frame-level model.
// Every cycle's outputs are predicted from a byte-list view of the current command and a record queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_spi_command_dispatcher;

  localparam logic [7:0] SAVE  = 8'h01;
  localparam logic [7:0] DRAW  = 8'h02;
  localparam int         IDW   = 5;
  localparam int         DEPTH = 8;
  localparam int         AW    = IDW + 9;
  localparam int         CW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cs;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          draw_valid;
  logic [47:0]   draw_data;
  logic          draw_ready;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          err_unknown_cmd;
  logic          err_bad_id;
  logic [7:0]    drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: bytes of the command in progress, queued draw records, drop tally.
  logic [7:0]  frame[$];
  logic [47:0] fq[$];
  int          drops   = 0;
  int          we_cnt  = 0;
  int          bad_cnt = 0;
  int          unk_cnt = 0;

  spi_command_dispatcher #(
    .CMD_SAVE_SPRITE (SAVE),
    .CMD_DRAW_SPRITE (DRAW),
    .SPRITE_ID_W     (IDW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .cs              (cs),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .draw_valid      (draw_valid),
    .draw_data       (draw_data),
    .draw_ready      (draw_ready),
    .fifo_count      (fifo_count),
    .busy            (busy),
    .err_unknown_cmd (err_unknown_cmd),
    .err_bad_id      (err_bad_id),
    .drop_count      (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare every output.
  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    logic          e_we;
    logic          e_bad;
    logic          e_unk;
    logic          push;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_wd;
    logic [47:0]   rec;
    logic [7:0]    id;
    int            idx;
    e_we = 1'b0; e_bad = 1'b0; e_unk = 1'b0; push = 1'b0;
    e_addr = '0; e_wd = '0; rec = '0; id = '0; idx = 0;
    byte_valid = v; byte_data = d; cs = c; draw_ready = r;

    if (c) begin
      frame.delete();
    end else if (v) begin
      frame.push_back(d);
      if (frame[0] == SAVE) begin
        if (frame.size() == 2 && int'(d) >= (1 << IDW)) e_bad = 1'b1;
        if (frame.size() >= 3) begin
          id  = frame[1];
          idx = frame.size() - 3;
          if (int'(id) < (1 << IDW)) begin
            e_we   = 1'b1;
            e_addr = AW'(int'(id) * 512 + idx);
            e_wd   = d;
          end
          if (idx == 511) frame.delete();
        end
      end else if (frame[0] == DRAW) begin
        if (frame.size() == 7) begin
          rec  = {frame[1], frame[2], frame[3], frame[4], frame[5], frame[6]};
          push = 1'b1;
          frame.delete();
        end
      end else begin
        e_unk = 1'b1;
        frame.delete();
      end
    end

    if (r && fq.size() != 0) void'(fq.pop_front());
    if (push) begin
      if (fq.size() < DEPTH) fq.push_back(rec);
      else if (drops < 255) drops++;
    end

    @(posedge clock);
    #1;
    if (mem_we) we_cnt++;
    if (err_bad_id) bad_cnt++;
    if (err_unknown_cmd) unk_cnt++;

    check("mem_we", 64'(mem_we), 64'(e_we));
    if (e_we) begin
      check("mem_addr", 64'(mem_addr), 64'(e_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    end
    check("err_bad_id", 64'(err_bad_id), 64'(e_bad));
    check("err_unknown_cmd", 64'(err_unknown_cmd), 64'(e_unk));
    check("busy", 64'(busy), 64'(frame.size() != 0));
    check("draw_valid", 64'(draw_valid), 64'(fq.size() != 0));
    if (fq.size() != 0) check("draw_data", 64'(draw_data), 64'(fq[0]));
    check("fifo_count", 64'(fifo_count), 64'(fq.size()));
    check("drop_count", 64'(drop_count), 64'(drops));
  endtask

  task automatic send(input logic [7:0] d, input logic r);
    step(1'b1, d, 1'b0, r);
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(1'b0, 8'h00, 1'b0, r);
  endtask

  task automatic draw_cmd(input logic [47:0] a, input logic r);
    send(DRAW, r);
    for (int i = 5; i >= 0; i--) send(a[i*8 +: 8], r);
  endtask

  // Random-traffic byte: optional idle gap, random ready, rare chip-select abort.
  task automatic rsend(input logic [7:0] d);
    if ($urandom_range(0, 3) == 0)
      step(1'b0, 8'h00, ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));
    step(1'b1, d, ($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)));
  endtask

  function automatic logic [47:0] rand_args();
    return {16'($urandom), 32'($urandom)};
  endfunction

  initial begin
    int          w0;
    int          b0;
    int          u0;
    int          saves;
    int          kind;
    logic [47:0] a;

    reset = 1'b1; cs = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; draw_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_draw_valid", 64'(draw_valid), 64'd0);
    check("rst_draw_data", 64'(draw_data), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_unk", 64'(err_unknown_cmd), 64'd0);
    check("rst_err_bad", 64'(err_bad_id), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    reset = 1'b0;
    idle(2, 1'b0);

    // Upload sprite 3 with pixel value = index, back to back.
    w0 = we_cnt;
    send(SAVE, 1'b0);
    send(8'd3, 1'b0);
    for (int i = 0; i < 512; i++) send(8'(i), 1'b0);
    check("upload_writes", 64'(we_cnt - w0), 64'd512);
    check("upload_busy_low", 64'(busy), 64'd0);
    idle(2, 1'b0);

    // Out-of-range id: one error, no writes, then a normal draw.
    w0 = we_cnt; b0 = bad_cnt;
    send(SAVE, 1'b0);
    send(8'd40, 1'b0);
    for (int i = 0; i < 512; i++) send(8'($urandom), 1'b0);
    check("badid_errs", 64'(bad_cnt - b0), 64'd1);
    check("badid_writes", 64'(we_cnt - w0), 64'd0);
    check("badid_idle", 64'(busy), 64'd0);
    draw_cmd(rand_args(), 1'b0);
    idle(2, 1'b1);

    // Known draw record held until accepted.
    draw_cmd(48'h07012C00F081, 1'b0);
    check("draw_rec", 64'(draw_data), 64'h07012C00F081);
    check("draw_cnt1", 64'(fifo_count), 64'd1);
    idle(3, 1'b0);
    check("draw_hold", 64'(draw_data), 64'h07012C00F081);
    idle(1, 1'b1);
    check("draw_cnt0", 64'(fifo_count), 64'd0);

    // Overfill: ninth record is dropped.
    repeat (9) draw_cmd(rand_args(), 1'b0);
    check("full_cnt", 64'(fifo_count), 64'd8);
    check("full_drop", 64'(drop_count), 64'd1);
    // Final argument byte coincides with a pop: accepted, count stays at 8.
    a = rand_args();
    send(DRAW, 1'b0);
    for (int i = 5; i >= 1; i--) send(a[i*8 +: 8], 1'b0);
    send(a[7:0], 1'b1);
    check("full_pop_cnt", 64'(fifo_count), 64'd8);
    check("full_pop_drop", 64'(drop_count), 64'd1);
    idle(10, 1'b1);

    // Abort mid-upload, then draw.
    w0 = we_cnt;
    send(SAVE, 1'b0);
    send(8'd1, 1'b0);
    for (int i = 0; i < 100; i++) send(8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("abort_busy", 64'(busy), 64'd0);
    draw_cmd(48'h1F0010002003, 1'b0);
    idle(2, 1'b0);
    check("abort_writes", 64'(we_cnt - w0), 64'd100);
    check("abort_draw", 64'(draw_data), 64'h1F0010002003);
    idle(2, 1'b1);

    // Unknown opcode then draw.
    u0 = unk_cnt;
    send(8'hEE, 1'b0);
    draw_cmd(48'h05ABCD123456, 1'b0);
    check("unk_pulses", 64'(unk_cnt - u0), 64'd1);
    check("unk_draw", 64'(draw_data), 64'h05ABCD123456);
    idle(2, 1'b1);

    // Byte coinciding with chip select is discarded.
    send(SAVE, 1'b0);
    step(1'b1, 8'h05, 1'b1, 1'b0);
    check("cs_wins_busy", 64'(busy), 64'd0);
    idle(2, 1'b0);

    // Random traffic.
    saves = 0;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0 && saves < 3) begin
        saves++;
        rsend(SAVE);
        rsend(8'($urandom_range(0, 63)));
        repeat (512) rsend(8'($urandom));
      end else if (kind <= 2) begin
        rsend(8'($urandom_range(3, 255)));
      end else begin
        a = rand_args();
        rsend(DRAW);
        for (int i = 5; i >= 0; i--) rsend(a[i*8 +: 8]);
      end
    end
    idle(20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_command_dispatcher.md
# spi_command_dispatcher

Sequences the SPI command byte stream into the sprite subsystem. Consumes framed bytes from the SPI byte reader and decodes SAVE_SPRITE and DRAW_SPRITE commands. SAVE_SPRITE becomes a run of sprite-memory write strobes; DRAW_SPRITE becomes a 48-bit draw record pushed into an internal FIFO that the draw engine pops with valid/ready. Sits between `spi_byte_reader` and the sprite RAM write port / draw engine, and supersedes `spi_command_parser` for those consumers.

## Interface
- `CMD_SAVE_SPRITE`, default `COMMAND_SAVE_SPRITE` (params.vh): opcode for sprite upload.
- `CMD_DRAW_SPRITE`, default `COMMAND_DRAW_SPRITE` (params.vh): opcode for draw request.
- `SPRITE_ID_W`, default 5: valid sprite ids are 0..2**SPRITE_ID_W-1.
- `FIFO_DEPTH`, default 8: draw FIFO depth; must be a power of 2, ≥2.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `cs` in 1: SPI chip select, high = inactive; frame abort.
- `byte_valid` in 1: one-cycle pulse, new byte on `byte_data`.
- `byte_data` in 8: received byte.
- `mem_we` out 1: sprite RAM write strobe.
- `mem_addr` out SPRITE_ID_W+9: `{sprite_id, pixel_index[8:0]}`.
- `mem_wdata` out 8: pixel byte.
- `draw_valid` out 1: FIFO head valid.
- `draw_data` out 48: `{id[7:0], x[15:0], y[15:0], flags[7:0]}`.
- `draw_ready` in 1: consumer accepts head.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `busy` out 1: state ≠ IDLE.
- `err_unknown_cmd` out 1: one-cycle pulse.
- `err_bad_id` out 1: one-cycle pulse.
- `drop_count` out 8: saturating count of draw records dropped on a full FIFO.

## Operation
- States: IDLE, SAVE_ID, SAVE_PIX, DRAW_ARGS.
- IDLE: on `byte_valid`, the byte is an opcode.
  - `CMD_SAVE_SPRITE` → SAVE_ID.
  - `CMD_DRAW_SPRITE` → DRAW_ARGS with arg_cnt=0.
  - Any other opcode: stay in IDLE and pulse `err_unknown_cmd`.
- SAVE_ID: next byte latched as `sprite_id`, pix_cnt=0, → SAVE_PIX.
  - If the id is ≥ 2**SPRITE_ID_W: pulse `err_bad_id` and set `suppress`. SAVE_PIX still consumes 512 bytes but issues no writes.
- SAVE_PIX: each byte produces one write (`mem_we`=1, addr `{sprite_id[SPRITE_ID_W-1:0], pix_cnt}`, data=byte) unless `suppress` is set. pix_cnt increments. After the byte with pix_cnt=511 → IDLE.
- DRAW_ARGS: bytes in order are id, x_hi, x_lo, y_hi, y_lo, flags, assembled into a shift register. On the 6th byte, the record is pushed → IDLE.
  - Ids are not range-checked here.
- FIFO push rule: push is accepted if `fifo_count < FIFO_DEPTH`, or if a pop happens in the same cycle (count unchanged). Otherwise the record is discarded and `drop_count` increments, saturating at 255.
- FIFO pop: `draw_valid && draw_ready`. `draw_data` is first-word-fall-through and stable while `draw_valid && !draw_ready`.
- `cs`=1 at any cycle: state → IDLE, counters and partial record cleared, `suppress` cleared. Writes already issued stand. FIFO contents and `drop_count` are kept. Bytes are ignored while `cs`=1.
- `cs` and `byte_valid` high in the same cycle: `cs` wins and the byte is dropped.
- `reset`: state IDLE, FIFO empty. All outputs 0: `mem_we`, `mem_addr`, `mem_wdata`, `draw_valid`, `draw_data`, `fifo_count`, `busy`, both error pulses, `drop_count`.

## Timing
- Inputs sampled on the rising edge of `clock`. All outputs registered.
- `mem_we`/`mem_addr`/`mem_wdata`: asserted the cycle after the pixel byte's `byte_valid`, for exactly 1 cycle.
- `err_*` pulses: the cycle after the offending byte, for 1 cycle.
- Draw record: with the FIFO empty, `draw_valid`=1 the cycle after the 6th arg byte. `fifo_count` updates in the same cycle.
- `busy` rises the cycle after a valid opcode. It falls the cycle after the last data byte or `cs` abort.
- Back-to-back `byte_valid` on consecutive cycles must be handled with no stall.

## Test plan
- Upload: opcode SAVE, id=3, bytes 0..511 mod 256 → 512 `mem_we` pulses, addr 0x600..0x7FF, wdata = index[7:0]; `busy` falls after the last pulse.
- Bad id: SAVE, id=40, 512 bytes → one `err_bad_id`, zero `mem_we`, then IDLE. A following DRAW is decoded correctly.
- Draw: DRAW, bytes 07 01 2C 00 F0 81 with `draw_ready`=0 → `draw_valid`=1, `draw_data`=0x07_012C_00F0_81, `fifo_count`=1. Held stable until `draw_ready`=1, then `fifo_count`=0.
- FIFO full: 9 DRAWs with `draw_ready`=0 → `fifo_count`=8, `drop_count`=1. The 9th record is absent. Then issue a DRAW with the final byte landing on a pop cycle → accepted and count stays 8.
- Abort: SAVE, id=1, 100 pixels, `cs`=1 for 1 cycle, then DRAW + 6 bytes → 100 writes only, the DRAW record is correct, and no leftover pixel writes occur.
- Unknown opcode 0xEE, then a valid DRAW → one `err_unknown_cmd` pulse, and the DRAW record is correct.
